// File: rtl/i2s_rx_master_if.sv
// Bus bundle for the I2S master receiver: run control, I2S pins and the
// sample-pair valid/ready output port.
interface i2s_rx_master_if #(
  parameter int WIDTH = 24
);
  logic             enable;
  logic             I2S_bclk_out;
  logic             I2S_wclk_out;
  logic             I2S_din0;
  logic [WIDTH-1:0] left_data;
  logic [WIDTH-1:0] right_data;
  logic             sample_valid;
  logic             sample_ready;
  logic             overrun;

  // Handshake: a pair transfers on every mclk edge where sample_valid and
  // sample_ready are both 1; while valid is high and no new pair lands,
  // left_data/right_data hold stable.
  modport master (
    input  enable, I2S_din0, sample_ready,
    output I2S_bclk_out, I2S_wclk_out, left_data, right_data, sample_valid, overrun
  );

  modport slave (
    output enable, I2S_din0, sample_ready,
    input  I2S_bclk_out, I2S_wclk_out, left_data, right_data, sample_valid, overrun
  );
endinterface

// File: rtl/i2s_rx_master.sv
// I2S master receiver: divides mclk into bclk/wclk, deserializes din into
// left/right sample pairs and presents them on a valid/ready port.
module i2s_rx_master #(
  parameter int WIDTH     = 24,
  parameter int SLOT_BITS = 32,
  parameter int BCLK_HALF = 4
) (
  input logic              mclk_in,
  input logic              rst,
  i2s_rx_master_if.master  bus
);
  localparam int FRAME = 2 * SLOT_BITS;
  localparam int CW    = $clog2(FRAME);
  localparam int DW    = (BCLK_HALF > 1) ? $clog2(BCLK_HALF) : 1;

  logic [DW-1:0]    div;
  logic             bclk;
  logic             wclk;
  logic [CW-1:0]    bit_cnt;
  logic [CW-1:0]    next_cnt;
  logic [CW-1:0]    pos;
  logic [WIDTH-1:0] shift;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] left_hold;
  logic             pend;
  logic             tick;
  logic             rise_ev;
  logic             capture;
  logic             last_bit;

  assign tick       = bus.enable && (div == DW'(BCLK_HALF - 1));
  assign rise_ev    = tick && !bclk;
  assign next_cnt   = (bit_cnt == CW'(FRAME - 1)) ? '0 : bit_cnt + 1'b1;
  // wclk always tracks bit_cnt >= SLOT_BITS, so it doubles as the slot select.
  assign pos        = wclk ? (bit_cnt - CW'(SLOT_BITS)) : bit_cnt;
  assign capture    = rise_ev && (pos != '0) && (pos <= CW'(WIDTH));
  assign last_bit   = rise_ev && (pos == CW'(WIDTH));
  assign shift_next = {shift[WIDTH-2:0], bus.I2S_din0};

  assign bus.I2S_bclk_out = bclk;
  assign bus.I2S_wclk_out = wclk;

  always_ff @(posedge mclk_in or posedge rst) begin
    if (rst) begin
      div       <= '0;
      bclk      <= 1'b0;
      wclk      <= 1'b0;
      bit_cnt   <= '0;
      shift     <= '0;
      left_hold <= '0;
      pend      <= 1'b0;
    end else begin
      pend <= last_bit && wclk;
      if (!bus.enable) begin
        div     <= '0;
        bclk    <= 1'b0;
        wclk    <= 1'b0;
        bit_cnt <= '0;
        shift   <= '0;
      end else begin
        if (tick) begin
          div  <= '0;
          bclk <= !bclk;
          if (bclk) begin
            bit_cnt <= next_cnt;
            wclk    <= (next_cnt >= CW'(SLOT_BITS));
          end
        end else begin
          div <= div + 1'b1;
        end
        if (capture) shift <= shift_next;
        if (last_bit && !wclk) left_hold <= shift_next;
      end
    end
  end

  // Output stage stays live while disabled so a held pair can still drain.
  always_ff @(posedge mclk_in or posedge rst) begin
    if (rst) begin
      bus.left_data    <= '0;
      bus.right_data   <= '0;
      bus.sample_valid <= 1'b0;
      bus.overrun      <= 1'b0;
    end else begin
      bus.sample_valid <= pend || (bus.sample_valid && !bus.sample_ready);
      if (pend) begin
        bus.left_data  <= left_hold;
        bus.right_data <= shift;
        if (bus.sample_valid && !bus.sample_ready) bus.overrun <= 1'b1;
      end
    end
  end
endmodule
